// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash stand-in: decodes READ/PROGRAM/WREN/WRDI/RDSR and serves a
// synchronous byte-memory port. All SPI inputs are resynchronised into clk.
//
// state  | meaning
// IDLE   | cs high, or reset seen while cs low; waiting for cs fall
// OPCODE | shifting in the 8-bit command
// ADDR   | shifting in the 24-bit address (read or program)
// READ   | streaming memory bytes on miso, prefetching the next byte
// PROG   | writing each completed mosi byte, page-wrapped
// RDSR   | repeatedly shifting out {6'b0, WEL, WIP}
// IGNORE | miso low until cs rises; WREN/WRDI wait here for cs rise
module spi_flash_responder #(
    parameter int MEM_AW           = 16,
    parameter int PROG_BUSY_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              status_wel,
    output logic              status_wip,
    output logic              active
);
    localparam int WCW = $clog2(PROG_BUSY_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, READ, PROG, RDSR, IGNORE} state_t;

    state_t         state;
    logic [2:0]     sck_sy, cs_sy;
    logic [1:0]     mosi_sy;
    logic [2:0]     bit_cnt;
    logic [1:0]     addr_bytes;
    logic [7:0]     rx_sh, tx_sh, pf;
    logic [23:0]    addr;
    logic [WCW-1:0] wip_cnt;
    logic           is_read, wren_pend, wrdi_pend, prog_wrote, rd_q, fresh;

    // Synchronisers are not reset so a reset inside a transaction cannot fake a cs fall.
    always_ff @(posedge clk) begin
        sck_sy  <= {sck_sy[1:0], sck};
        cs_sy   <= {cs_sy[1:0], cs};
        mosi_sy <= {mosi_sy[0], mosi};
    end

    logic        sck_rise, sck_fall, cs_rise, cs_fall;
    logic [7:0]  rx_next, status_byte;
    logic [23:0] addr_next, addr_inc;

    assign sck_rise    = sck_sy[1] & ~sck_sy[2];
    assign sck_fall    = ~sck_sy[1] & sck_sy[2];
    assign cs_rise     = cs_sy[1] & ~cs_sy[2];
    assign cs_fall     = ~cs_sy[1] & cs_sy[2];
    assign rx_next     = {rx_sh[6:0], mosi_sy[1]};
    assign addr_next   = {addr[22:0], mosi_sy[1]};
    assign addr_inc    = addr + 24'd1;
    assign status_byte = {6'b0, status_wel, status_wip};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            miso       <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            status_wel <= 1'b0;
            status_wip <= 1'b0;
            active     <= 1'b0;
            wip_cnt    <= '0;
            bit_cnt    <= '0;
            addr_bytes <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            pf         <= '0;
            addr       <= '0;
            is_read    <= 1'b0;
            wren_pend  <= 1'b0;
            wrdi_pend  <= 1'b0;
            prog_wrote <= 1'b0;
            rd_q       <= 1'b0;
            fresh      <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            active <= ~cs_sy[1];
            rd_q   <= mem_re;

            if (wip_cnt != '0) begin
                wip_cnt <= wip_cnt - WCW'(1);
                if (wip_cnt == WCW'(1)) status_wip <= 1'b0;
            end

            // mem_rdata is valid the cycle after the strobe
            if (rd_q) begin
                pf <= mem_rdata;
                if (fresh) begin
                    tx_sh <= mem_rdata;
                    miso  <= mem_rdata[7];
                    fresh <= 1'b0;
                end
            end

            if (cs_rise) begin
                state <= IDLE;
                miso  <= 1'b0;
                fresh <= 1'b0;
                if (state == PROG) begin
                    status_wel <= 1'b0;
                    if (prog_wrote) begin
                        status_wip <= 1'b1;
                        wip_cnt    <= WCW'(PROG_BUSY_CYCLES);
                    end
                end else if (wren_pend) begin
                    status_wel <= 1'b1;
                end else if (wrdi_pend) begin
                    status_wel <= 1'b0;
                end
            end else if (cs_fall) begin
                state      <= OPCODE;
                miso       <= 1'b0;
                bit_cnt    <= '0;
                addr_bytes <= '0;
                wren_pend  <= 1'b0;
                wrdi_pend  <= 1'b0;
                prog_wrote <= 1'b0;
                fresh      <= 1'b0;
            end else begin
                case (state)
                    OPCODE: if (sck_rise) begin
                        rx_sh   <= rx_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (rx_next)
                                8'h03: begin is_read <= 1'b1; state <= ADDR; end
                                8'h02: begin
                                    is_read <= 1'b0;
                                    state   <= (status_wel && !status_wip) ? ADDR : IGNORE;
                                end
                                8'h06: begin wren_pend <= 1'b1; state <= IGNORE; end
                                8'h04: begin wrdi_pend <= 1'b1; state <= IGNORE; end
                                8'h05: begin
                                    tx_sh <= status_byte;
                                    miso  <= status_byte[7];
                                    state <= RDSR;
                                end
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: if (sck_rise) begin
                        addr    <= addr_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr_bytes <= addr_bytes + 2'd1;
                            if (addr_bytes == 2'd2) begin
                                if (is_read) begin
                                    mem_re   <= 1'b1;
                                    mem_addr <= addr_next[MEM_AW-1:0];
                                    fresh    <= 1'b1;
                                    state    <= READ;
                                end else begin
                                    state <= PROG;
                                end
                            end
                        end
                    end
                    READ: begin
                        // Prefetch on the MSB rise; the boundary fall then loads pf.
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd0) begin
                                addr     <= addr_inc;
                                mem_re   <= 1'b1;
                                mem_addr <= addr_inc[MEM_AW-1:0];
                            end
                        end else if (sck_fall) begin
                            if (bit_cnt == 3'd0) begin
                                tx_sh <= pf;
                                miso  <= pf[7];
                            end else begin
                                tx_sh <= {tx_sh[6:0], 1'b0};
                                miso  <= tx_sh[6];
                            end
                        end
                    end
                    PROG: if (sck_rise) begin
                        rx_sh   <= rx_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            mem_we     <= 1'b1;
                            mem_wdata  <= rx_next;
                            mem_addr   <= addr[MEM_AW-1:0];
                            addr[7:0]  <= addr[7:0] + 8'd1;
                            prog_wrote <= 1'b1;
                        end
                    end
                    RDSR: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (sck_fall) begin
                            if (bit_cnt == 3'd0) begin
                                tx_sh <= status_byte;
                                miso  <= status_byte[7];
                            end else begin
                                tx_sh <= {tx_sh[6:0], 1'b0};
                                miso  <= tx_sh[6];
                            end
                        end
                    end
                    IGNORE: if (sck_rise) begin
                        // any ninth bit cancels a pending WREN/WRDI
                        wren_pend <= 1'b0;
                        wrdi_pend <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a bit-banged SPI master plus a
// byte memory that logs every write strobe.
module tb_spi_flash_responder;
    localparam int HALF = 80;

    logic        clk = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic        miso, mem_re, mem_we, status_wel, status_wip, active;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00, mem_wdata;

    logic [7:0]  mem [0:65535];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    spi_flash_responder #(.MEM_AW(16), .PROG_BUSY_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .status_wel(status_wel), .status_wip(status_wip), .active(active)
    );

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            #(HALF);
            sck = 1'b1;
            rx = {rx[6:0], miso};
            #(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic xfer8(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic cs_on();
        @(negedge clk);
        cs = 1'b0;
        #(HALF);
    endtask

    task automatic cs_off();
        #(HALF);
        cs = 1'b1;
        #(4*HALF);
    endtask

    task automatic cmd1(input logic [7:0] op);
        logic [7:0] d;
        cs_on();
        xfer8(op, d);
        cs_off();
    endtask

    task automatic rdsr2(output logic [7:0] s0, output logic [7:0] s1);
        logic [7:0] d;
        cs_on();
        xfer8(8'h05, d);
        xfer8(8'h00, s0);
        xfer8(8'h00, s1);
        cs_off();
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++;
        if ({miso, mem_re, mem_we, status_wel, status_wip, active} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000",
                     {miso, mem_re, mem_we, status_wel, status_wip, active});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 24'h0) begin
            errors++;
            $display("FAIL reset_bus got %h exp 000000", {mem_addr, mem_wdata});
        end
        rst = 1'b0;
        cs_on();
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL active_low_cs got %b exp 1", active);
        end
        cs_off();
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL active_high_cs got %b exp 0", active);
        end
    endtask

    task automatic test_wren_rdsr();
        logic [7:0] s0, s1;
        cmd1(8'h06);
        checks++;
        if (status_wel !== 1'b1) begin
            errors++;
            $display("FAIL wren_wel got %b exp 1", status_wel);
        end
        rdsr2(s0, s1);
        checks++;
        if ({s0, s1} !== 16'h0202) begin
            errors++;
            $display("FAIL rdsr_wel got %h exp 0202", {s0, s1});
        end
    endtask

    task automatic test_program();
        logic [7:0] d, s0, s1;
        logic [7:0] seq [7];
        seq = '{8'h02, 8'h00, 8'h12, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
        cmd1(8'h06);
        cs_on();
        foreach (seq[i]) xfer8(seq[i], d);
        cs_off();
        checks++;
        if (wa_q.size() !== 3) begin
            errors++;
            $display("FAIL prog_count got %0d exp 3", wa_q.size());
        end else begin
            checks++;
            if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1], wa_q[2], wd_q[2]} !==
                {16'h12FE, 8'hAA, 16'h12FF, 8'hBB, 16'h1200, 8'hCC}) begin
                errors++;
                $display("FAIL prog_writes got %h:%h %h:%h %h:%h exp 12fe:aa 12ff:bb 1200:cc",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1], wa_q[2], wd_q[2]);
            end
        end
        checks++;
        if ({status_wel, status_wip} !== 2'b01) begin
            errors++;
            $display("FAIL prog_busy got wel/wip %b exp 01", {status_wel, status_wip});
        end
        repeat (80) @(negedge clk);
        checks++;
        if (status_wip !== 1'b0) begin
            errors++;
            $display("FAIL wip_clear got %b exp 0", status_wip);
        end
        rdsr2(s0, s1);
        checks++;
        if ({s0, s1} !== 16'h0000) begin
            errors++;
            $display("FAIL rdsr_after_prog got %h exp 0000", {s0, s1});
        end
    endtask

    task automatic test_read();
        logic [7:0] d, r0, r1, r2;
        mem[16'h1300] = 8'h5C;
        mem[16'h1200] = 8'h77;
        cs_on();
        xfer8(8'h03, d); xfer8(8'h00, d); xfer8(8'h12, d); xfer8(8'hFE, d);
        xfer8(8'h00, r0); xfer8(8'h00, r1); xfer8(8'h00, r2);
        cs_off();
        checks++;
        if ({r0, r1, r2} !== 24'hAABB5C) begin
            errors++;
            $display("FAIL read_stream got %h exp aabb5c", {r0, r1, r2});
        end
        checks++;
        if (wa_q.size() !== 3) begin
            errors++;
            $display("FAIL read_no_write got %0d exp 3", wa_q.size());
        end
    endtask

    task automatic test_prog_no_wren();
        logic [7:0] d, s0, s1;
        cs_on();
        xfer8(8'h02, d); xfer8(8'h00, d); xfer8(8'h30, d); xfer8(8'h00, d);
        xfer8(8'h55, d); xfer8(8'h66, d);
        cs_off();
        checks++;
        if (wa_q.size() !== 3) begin
            errors++;
            $display("FAIL nowren_writes got %0d exp 3", wa_q.size());
        end
        rdsr2(s0, s1);
        checks++;
        if ({s0, s1} !== 16'h0000) begin
            errors++;
            $display("FAIL nowren_status got %h exp 0000", {s0, s1});
        end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        cs_on();
        xfer_bits(8'h06, 5, d);
        cs_off();
        checks++;
        if (status_wel !== 1'b0) begin
            errors++;
            $display("FAIL wren_partial got %b exp 0", status_wel);
        end
        cmd1(8'h06);
        cs_on();
        xfer8(8'h02, d); xfer8(8'h00, d); xfer8(8'h20, d); xfer8(8'h00, d);
        xfer8(8'h11, d);
        xfer_bits(8'h22, 4, d);
        cs_off();
        checks++;
        if (wa_q.size() !== 4) begin
            errors++;
            $display("FAIL abort_count got %0d exp 4", wa_q.size());
        end else begin
            checks++;
            if ({wa_q[3], wd_q[3]} !== {16'h2000, 8'h11}) begin
                errors++;
                $display("FAIL abort_write got %h:%h exp 2000:11", wa_q[3], wd_q[3]);
            end
        end
        checks++;
        if ({status_wel, status_wip} !== 2'b01) begin
            errors++;
            $display("FAIL abort_busy got %b exp 01", {status_wel, status_wip});
        end
        repeat (80) @(negedge clk);
    endtask

    task automatic test_wrdi();
        cmd1(8'h06);
        cmd1(8'h04);
        checks++;
        if (status_wel !== 1'b0) begin
            errors++;
            $display("FAIL wrdi_wel got %b exp 0", status_wel);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d, r0, r1, s0, s1;
        cmd1(8'h06);
        cs_on();
        xfer8(8'h03, d); xfer8(8'h00, d); xfer8(8'h12, d); xfer8(8'hFE, d);
        xfer8(8'h00, r0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        xfer8(8'hFF, r1);
        checks++;
        if ({r0, r1, miso} !== {8'hAA, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_read got %h %h miso %b exp aa 00 0", r0, r1, miso);
        end
        checks++;
        if ({status_wel, status_wip} !== 2'b00) begin
            errors++;
            $display("FAIL reset_status got %b exp 00", {status_wel, status_wip});
        end
        cs_off();
        rdsr2(s0, s1);
        checks++;
        if ({s0, s1} !== 16'h0000) begin
            errors++;
            $display("FAIL rdsr_post_reset got %h exp 0000", {s0, s1});
        end
        cmd1(8'h06);
        rdsr2(s0, s1);
        checks++;
        if ({s0, s1} !== 16'h0202) begin
            errors++;
            $display("FAIL rdsr_resume got %h exp 0202", {s0, s1});
        end
    endtask

    initial begin
        test_reset();
        test_wren_rdsr();
        test_program();
        test_read();
        test_prog_no_wren();
        test_abort();
        test_wrdi();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
